// File: rtl/sr_to_jk_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_to_jk_if
// Description : Bundles the SR request inputs and the JK excitation outputs
//               of the SR-to-JK converter.
//               The master drives S/R and observes J/K.
//               The slave (the converter) samples S/R and drives J/K.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_to_jk_if;
  logic S;  // set request
  logic R;  // clear request
  logic J;  // registered JK set excitation
  logic K;  // registered JK clear excitation

  modport master (
    output S,
    output R,
    input  J,
    input  K
  );

  modport slave (
    input  S,
    input  R,
    output J,
    output K
  );
endinterface : sr_to_jk_if
`default_nettype wire

// File: rtl/sr_to_jk.sv
`default_nettype none
// ============================================================================
// Module      : sr_to_jk
// Description : Clocked SR-to-JK excitation converter. A one-bit state is
//               advanced from the S/R requests. S=R=1 toggles the state.
//               Every edge registers the minimal JK pair that reproduces the
//               transition just taken:
//                 - J pulses on a 0->1 change.
//                 - K pulses on a 1->0 change.
//               A JK flip-flop fed from J/K therefore tracks the state one
//               cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_to_jk (
  input  wire logic   CLK,
  input  wire logic   RST,
  sr_to_jk_if.slave   bus
);

  // The tracked state is treated as a two-state FSM so that the transition
  // (old state -> new state) is explicit when deriving the excitation.
  localparam logic [0:0] ST_CLR = 1'b0;
  localparam logic [0:0] ST_SET = 1'b1;

  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       j_q;
  logic       j_d;
  logic       k_q;
  logic       k_d;

  // State and excitation registers; reset clears everything asynchronously
  // and discards any transition that was pending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_CLR;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Next state from the SR request; the otherwise-invalid S=R=1 case toggles.
  always_comb begin
    state_d = state_q;
    case ({bus.S, bus.R})
      2'b00:   state_d = state_q;
      2'b10:   state_d = ST_SET;
      2'b01:   state_d = ST_CLR;
      2'b11:   state_d = (state_q == ST_SET) ? ST_CLR : ST_SET;
      default: state_d = state_q;
    endcase
  end

  // Minimal excitation for the transition about to be committed.
  // Only one of J/K can be set, since a single transition has one direction.
  always_comb begin
    j_d = 1'b0;
    k_d = 1'b0;
    if ((state_q == ST_CLR) && (state_d == ST_SET)) begin
      j_d = 1'b1;
    end
    if ((state_q == ST_SET) && (state_d == ST_CLR)) begin
      k_d = 1'b1;
    end
  end

  // Outputs come straight from flops; there is no input-to-output path.
  assign bus.J = j_q;
  assign bus.K = k_q;

endmodule : sr_to_jk
`default_nettype wire

// File: tb/tb_sr_to_jk.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_to_jk
// Description : Directed self-checking bench for sr_to_jk. Expected J/K
//               values are written by hand next to each step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_to_jk;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sr_to_jk_if bus ();

  sr_to_jk dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_jk(input string tag, input logic exp_j, input logic exp_k);
    check({tag, ".J"}, bus.J, exp_j);
    check({tag, ".K"}, bus.K, exp_k);
  endtask

  // Drive S/R at the falling edge.
  // Sample J/K 1 unit after the next rising edge.
  task automatic step(input logic s, input logic r, input logic exp_j,
                      input logic exp_k, input string tag);
    @(negedge clk);
    bus.S = s;
    bus.R = r;
    @(posedge clk);
    #1;
    check_jk(tag, exp_j, exp_k);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.S  = 1'b1;
    bus.R  = 1'b0;

    // Reset held with S=1 and the clock running: outputs stay 0.
    #1;
    check_jk("rst_t0", 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_hold0");
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst_hold1");

    // Release at a falling edge.
    // The first edge sets Q and pulses J.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_jk("rst_rel_first", 1'b1, 1'b0);   // Q: 0 -> 1

    // Sustained set gives a single J pulse.
    step(1'b1, 1'b0, 1'b0, 1'b0, "set_again");      // Q stays 1

    // Clear for two edges.
    step(1'b0, 1'b1, 1'b0, 1'b1, "clr_1");          // Q: 1 -> 0
    step(1'b0, 1'b1, 1'b0, 1'b0, "clr_2");          // Q stays 0

    // Hold with Q=0 for 3 edges; a later set proves Q stayed 0.
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold0_3");
    step(1'b1, 1'b0, 1'b1, 1'b0, "set_from0");      // Q: 0 -> 1

    // Hold with Q=1 for 3 edges; a later clear proves Q stayed 1.
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold1_1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold1_2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "hold1_3");
    step(1'b0, 1'b1, 1'b0, 1'b1, "clr_from1");      // Q: 1 -> 0

    // S=R=1 toggles every edge from Q=0.
    step(1'b1, 1'b1, 1'b1, 1'b0, "tog_1");          // Q -> 1
    step(1'b1, 1'b1, 1'b0, 1'b1, "tog_2");          // Q -> 0
    step(1'b1, 1'b1, 1'b1, 1'b0, "tog_3");          // Q -> 1
    step(1'b1, 1'b1, 1'b0, 1'b1, "tog_4");          // Q -> 0

    // Async reset mid-cycle while toggling, with J high at that moment.
    step(1'b1, 1'b1, 1'b1, 1'b0, "tog_5");          // Q -> 1, J=1
    #2;
    rst = 1'b1;
    #1;
    check_jk("async_rst_now", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_jk("async_rst_edge", 1'b0, 1'b0);

    // Release: Q restarts at 0, so toggling gives J first.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_jk("post_rst_tog1", 1'b1, 1'b0);          // Q: 0 -> 1
    step(1'b1, 1'b1, 1'b0, 1'b1, "post_rst_tog2");  // Q: 1 -> 0

    // Finish idle.
    step(1'b0, 1'b0, 1'b0, 1'b0, "final_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sr_to_jk
`default_nettype wire
